idecode: RTL and testbench

IDECODE -- requirements
Module: idecode

---
 rtl/mips_pkg.sv | 25 ++
 rtl/control.sv | 39 +++
 rtl/idecode.sv | 104 ++++++++++
 tb/tb_idecode.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings and control-field widths.
// Used by ifetch, idecode and the EX stage.
package mips_pkg;

  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int EX_W  = 4;

  // Bit position of MemRead inside the {Branch, MemRead, MemWrite} field
  localparam int MEM_READ_BIT = 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef logic [WB_W-1:0]  wb_t;
  typedef logic [MEM_W-1:0] mem_t;
  typedef logic [EX_W-1:0]  ex_t;

endpackage

// File: rtl/control.sv
// Main control decoder: opcode -> {wb, mem, ex} control groups.
// Unknown opcodes decode to an all-zero bubble.
module control
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output wb_t        wb,
  output mem_t       mem,
  output ex_t        ex
);

  // wb = {RegWrite, MemtoReg}, mem = {Branch, MemRead, MemWrite}, ex = {RegDst, ALUOp, ALUSrc}
  always_comb begin
    wb  = '0;
    mem = '0;
    ex  = '0;
    case (opcode)
      OP_RTYPE: begin
        wb = 2'b10;
        ex = {1'b1, ALUOP_FUNCT, 1'b0};
      end
      OP_LW: begin
        wb  = 2'b11;
        mem = 3'b010;
        ex  = {1'b0, ALUOP_ADD, 1'b1};
      end
      OP_SW: begin
        mem = 3'b001;
        ex  = {1'b0, ALUOP_ADD, 1'b1};
      end
      OP_BEQ: begin
        mem = 3'b100;
        ex  = {1'b0, ALUOP_SUB, 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: register file, control decode and ID/EX latch.
// Define ID_HAZARD_EN to enable load-use stall detection.
module idecode
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IF_ID_instr,
  input  logic [DATA_W-1:0] IF_ID_npc,
  input  logic              MEM_WB_RegWrite,
  input  logic [4:0]        MEM_WB_Writereg,
  input  logic [DATA_W-1:0] MEM_WB_Writedata,
  input  logic              EX_MEM_PCSrc,
  output logic [WB_W-1:0]   ID_EX_wb,
  output logic [MEM_W-1:0]  ID_EX_mem,
  output logic [EX_W-1:0]   ID_EX_ex,
  output logic [DATA_W-1:0] ID_EX_npc,
  output logic [DATA_W-1:0] ID_EX_readdat1,
  output logic [DATA_W-1:0] ID_EX_readdat2,
  output logic [DATA_W-1:0] ID_EX_sign_ext,
  output logic [4:0]        ID_EX_instr_2016,
  output logic [4:0]        ID_EX_instr_1511,
  output logic              ID_stall
);

  logic [DATA_W-1:0]        regs [32];
  logic [4:0]               rs_p0, rt_p0, rd_p0;
  logic                     wr_en;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0;
  logic signed [DATA_W-1:0] sign_ext_p0;
  wb_t                      wb_dec_p0;
  mem_t                     mem_dec_p0;
  ex_t                      ex_dec_p0;
  logic                     load_use_p0;
  logic                     bubble_p0;

  assign rs_p0 = IF_ID_instr[25:21];
  assign rt_p0 = IF_ID_instr[20:16];
  assign rd_p0 = IF_ID_instr[15:11];

  assign wr_en = MEM_WB_RegWrite && (MEM_WB_Writereg != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[MEM_WB_Writereg] <= MEM_WB_Writedata;
    end
  end

  // Write-through bypass so a same-cycle writeback is visible to this decode
  assign rd1_p0 = (rs_p0 == 5'd0) ? '0 :
                  (wr_en && (MEM_WB_Writereg == rs_p0)) ? MEM_WB_Writedata : regs[rs_p0];
  assign rd2_p0 = (rt_p0 == 5'd0) ? '0 :
                  (wr_en && (MEM_WB_Writereg == rt_p0)) ? MEM_WB_Writedata : regs[rt_p0];

  assign sign_ext_p0 = DATA_W'($signed(IF_ID_instr[15:0]));

  control u_control (
    .opcode (IF_ID_instr[31:26]),
    .wb     (wb_dec_p0),
    .mem    (mem_dec_p0),
    .ex     (ex_dec_p0)
  );

`ifdef ID_HAZARD_EN
  assign load_use_p0 = ID_EX_mem[MEM_READ_BIT] && (ID_EX_instr_2016 != 5'd0) &&
                       ((ID_EX_instr_2016 == rs_p0) || (ID_EX_instr_2016 == rt_p0));
`else
  assign load_use_p0 = 1'b0;
`endif

  // A taken branch squashes the slot anyway, so it overrides the stall request
  assign ID_stall  = load_use_p0 && !EX_MEM_PCSrc;
  assign bubble_p0 = EX_MEM_PCSrc || load_use_p0;

  // ID/EX pipeline boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_wb         <= '0;
      ID_EX_mem        <= '0;
      ID_EX_ex         <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      ID_EX_wb         <= bubble_p0 ? '0 : wb_dec_p0;
      ID_EX_mem        <= bubble_p0 ? '0 : mem_dec_p0;
      ID_EX_ex         <= bubble_p0 ? '0 : ex_dec_p0;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= rd1_p0;
      ID_EX_readdat2   <= rd2_p0;
      ID_EX_sign_ext   <= sign_ext_p0;
      ID_EX_instr_2016 <= rt_p0;
      ID_EX_instr_1511 <= rd_p0;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: directed cases plus randomized traffic against a reference model.
// Honors ID_HAZARD_EN the same way as the design build.
module tb_idecode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_instr, IF_ID_npc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_Writereg;
  logic [31:0] MEM_WB_Writedata;
  logic        EX_MEM_PCSrc;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_mem;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016, ID_EX_instr_1511;
  logic        ID_stall;

  idecode dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_npc        (IF_ID_npc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_Writereg  (MEM_WB_Writereg),
    .MEM_WB_Writedata (MEM_WB_Writedata),
    .EX_MEM_PCSrc     (EX_MEM_PCSrc),
    .ID_EX_wb         (ID_EX_wb),
    .ID_EX_mem        (ID_EX_mem),
    .ID_EX_ex         (ID_EX_ex),
    .ID_EX_npc        (ID_EX_npc),
    .ID_EX_readdat1   (ID_EX_readdat1),
    .ID_EX_readdat2   (ID_EX_readdat2),
    .ID_EX_sign_ext   (ID_EX_sign_ext),
    .ID_EX_instr_2016 (ID_EX_instr_2016),
    .ID_EX_instr_1511 (ID_EX_instr_1511),
    .ID_stall         (ID_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and expected ID/EX contents
  logic [31:0] m_regs [32];
  logic [1:0]  e_wb;
  logic [2:0]  e_mem;
  logic [3:0]  e_ex;
  logic [31:0] e_npc, e_rd1, e_rd2, e_sx;
  logic [4:0]  e_rt, e_rd;
  logic        obs_stall;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    e_wb = 0; e_mem = 0; e_ex = 0; e_npc = 0; e_rd1 = 0; e_rd2 = 0; e_sx = 0; e_rt = 0; e_rd = 0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                        input logic [31:0] wd);
    if (r == 0) return 32'h0;
    if (we && wr == r) return wd;
    return m_regs[r];
  endfunction

  // {wb[1:0], mem[2:0], ex[3:0]} straight from the opcode table
  function automatic logic [8:0] decode_tbl(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 4'b1100};
      6'h23:   return {2'b11, 3'b010, 4'b0001};
      6'h2B:   return {2'b00, 3'b001, 4'b0001};
      6'h04:   return {2'b00, 3'b100, 4'b0010};
      default: return 9'h0;
    endcase
  endfunction

  task automatic check_outs();
    chk("wb",   {30'h0, ID_EX_wb},  {30'h0, e_wb});
    chk("mem",  {29'h0, ID_EX_mem}, {29'h0, e_mem});
    chk("ex",   {28'h0, ID_EX_ex},  {28'h0, e_ex});
    chk("npc",  ID_EX_npc, e_npc);
    chk("rd1",  ID_EX_readdat1, e_rd1);
    chk("rd2",  ID_EX_readdat2, e_rd2);
    chk("sx",   ID_EX_sign_ext, e_sx);
    chk("rt",   {27'h0, ID_EX_instr_2016}, {27'h0, e_rt});
    chk("rd",   {27'h0, ID_EX_instr_1511}, {27'h0, e_rd});
  endtask

  task automatic cycle(input logic [31:0] instr, input logic [31:0] npc, input logic we,
                       input logic [4:0] wreg, input logic [31:0] wdata, input logic pcsrc);
    logic [4:0]  rs, rt;
    logic        load_use, stall;
    logic [8:0]  ctl;
    logic [31:0] r1, r2;
    IF_ID_instr = instr; IF_ID_npc = npc;
    MEM_WB_RegWrite = we; MEM_WB_Writereg = wreg; MEM_WB_Writedata = wdata;
    EX_MEM_PCSrc = pcsrc;
    rs = instr[25:21];
    rt = instr[20:16];
    r1 = mread(rs, we, wreg, wdata);
    r2 = mread(rt, we, wreg, wdata);
`ifdef ID_HAZARD_EN
    load_use = e_mem[1] && (e_rt != 0) && (e_rt == rs || e_rt == rt);
`else
    load_use = 1'b0;
`endif
    stall = load_use && !pcsrc;
    ctl = (load_use || pcsrc) ? 9'h0 : decode_tbl(instr[31:26]);
    #1;
    obs_stall = ID_stall;
    chk("stall", {31'h0, ID_stall}, {31'h0, stall});
    @(posedge clk);
    {e_wb, e_mem, e_ex} = ctl;
    e_npc = npc; e_rd1 = r1; e_rd2 = r2;
    e_sx = {{16{instr[15]}}, instr[15:0]};
    e_rt = rt; e_rd = instr[15:11];
    if (we && wreg != 0) m_regs[wreg] = wdata;
    #1;
    check_outs();
  endtask

  logic [31:0] rnd, instr;
  logic [5:0]  op;

  initial begin
    rst = 1'b1;
    IF_ID_instr = 0; IF_ID_npc = 0; MEM_WB_RegWrite = 0; MEM_WB_Writereg = 0;
    MEM_WB_Writedata = 0; EX_MEM_PCSrc = 0;
    model_reset();
    #3;
    check_outs();
    chk("rst_stall", {31'h0, ID_stall}, 32'h0);
    #4 rst = 1'b0;

    // r5 write, then add r3,r5,r0
    cycle(32'h0000_0000, 32'h4, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
    cycle(32'h00A0_1820, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("add_rd1", ID_EX_readdat1, 32'h1234);
    chk("add_rd2", ID_EX_readdat2, 32'h0);
    chk("add_wb",  {30'h0, ID_EX_wb}, 32'h2);
    chk("add_ex",  {28'h0, ID_EX_ex}, 32'hC);
    chk("add_rd",  {27'h0, ID_EX_instr_1511}, 32'h3);

    // r0 write discarded
    cycle(32'h0000_1020, 32'hC, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    chk("r0_same", ID_EX_readdat1, 32'h0);
    cycle(32'h0000_1020, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("r0_after", ID_EX_readdat2, 32'h0);

    // same-cycle bypass of r7
    cycle(32'h00E0_0020, 32'h14, 1'b1, 5'd7, 32'h0000_DEAD, 1'b0);
    chk("bypass", ID_EX_readdat1, 32'hDEAD);

    // lw r2,-4(r1), then again under a taken branch
    cycle(32'h8C22_FFFC, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lw_sx",  ID_EX_sign_ext, 32'hFFFF_FFFC);
    chk("lw_wb",  {30'h0, ID_EX_wb},  32'h3);
    chk("lw_mem", {29'h0, ID_EX_mem}, 32'h2);
    chk("lw_ex",  {28'h0, ID_EX_ex},  32'h1);
    chk("lw_rt",  {27'h0, ID_EX_instr_2016}, 32'h2);
    cycle(32'h8C22_FFFC, 32'h1C, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("flush_stall", {31'h0, obs_stall}, 32'h0);
    chk("flush_ctl", {23'h0, ID_EX_wb, ID_EX_mem, ID_EX_ex}, 32'h0);
    chk("flush_sx", ID_EX_sign_ext, 32'hFFFF_FFFC);

    // load-use: lw r2 then add r3,r2,r0
    cycle(32'h8C02_0000, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(32'h0040_1820, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef ID_HAZARD_EN
    chk("lu_stall", {31'h0, obs_stall}, 32'h1);
    chk("lu_bubble", {23'h0, ID_EX_wb, ID_EX_mem, ID_EX_ex}, 32'h0);
    cycle(32'h0040_1820, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lu_release", {31'h0, obs_stall}, 32'h0);
`else
    chk("lu_nostall", {31'h0, obs_stall}, 32'h0);
`endif
    chk("lu_add_wb", {30'h0, ID_EX_wb}, 32'h2);
    chk("lu_add_rd", {27'h0, ID_EX_instr_1511}, 32'h3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: begin rnd = $urandom(); op = rnd[5:0]; end
      endcase
      rnd = $urandom();
      instr = {op, 2'b00, rnd[23:21], 2'b00, rnd[18:16], rnd[15:0]};
      rnd = $urandom();
      cycle(instr, $urandom(), rnd[0], {2'b00, rnd[3:1]}, $urandom(), (rnd[7:5] == 3'd0));
    end

    // asynchronous reset mid-run with a pending r5 write
    cycle(32'h0000_0000, 32'h40, 1'b1, 5'd5, 32'h0000_CAFE, 1'b0);
    rst = 1'b1;
    IF_ID_instr = 32'h8CA5_0004;
    MEM_WB_RegWrite = 1'b1; MEM_WB_Writereg = 5'd5; MEM_WB_Writedata = 32'h0000_0055;
    #2;
    model_reset();
    check_outs();
    chk("mrst_stall", {31'h0, ID_stall}, 32'h0);
    @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;
    MEM_WB_RegWrite = 1'b0;
    cycle(32'h00A5_2020, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("mrst_r5a", ID_EX_readdat1, 32'h0);
    chk("mrst_r5b", ID_EX_readdat2, 32'h0);
    chk("mrst_dec", {30'h0, ID_EX_wb}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
